// File: rtl/mem_responder.sv
// Byte-serial memory responder: internal RAM with one-cycle registered reads.
// Define MEM_RESP_IO_EN to add the I/O window (TX FIFO, overflow flag, halt register).
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_a_i,
  input  logic [7:0]  mem_dout_i,
  output logic [7:0]  mem_din_o,
  output logic        io_tx_valid_o,
  output logic [7:0]  io_tx_data_o,
  input  logic        io_tx_ready_i,
  output logic        io_full_o,
  output logic        io_ovf_o,
  output logic        halt_o
);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic [7:0]            rd_data;

  assign ram_idx = mem_a_i[ADDR_WIDTH-1:0];

`ifdef MEM_RESP_IO_EN
  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic             is_io;
  logic [31:0]      io_off;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push;
  logic             halt_q;
  logic             ovf_q;

  assign is_io    = (mem_a_i >= IO_BASE);
  assign io_off   = mem_a_i - IO_BASE;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                    (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign pop      = !empty && io_tx_ready_i;
  assign push_req = mem_wr_i && is_io && (io_off == 32'd0) && !halt_q;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign ram_we   = mem_wr_i && !is_io && !halt_q;

  always_comb begin
    rd_data = 8'h00;
    if (!is_io) begin
      rd_data = ram[ram_idx];
    end else if (io_off == 32'd4) begin
      rd_data = {6'b0, full, empty};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst && push) begin
      fifo_mem[wr_ptr[IDX_W-1:0]] <= mem_dout_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      halt_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (mem_wr_i && is_io && (io_off == 32'd4)) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign io_tx_valid_o = !empty;
  assign io_tx_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr[IDX_W-1:0]];
  assign io_full_o     = full;
  assign io_ovf_o      = ovf_q;
  assign halt_o        = halt_q;
`else
  logic unused_io;

  assign ram_we        = mem_wr_i;
  assign rd_data       = ram[ram_idx];
  assign io_tx_valid_o = 1'b0;
  assign io_tx_data_o  = 8'h00;
  assign io_full_o     = 1'b0;
  assign io_ovf_o      = 1'b0;
  assign halt_o        = 1'b0;
  assign unused_io     = ^{io_tx_ready_i, mem_a_i[31:ADDR_WIDTH], IO_BASE, FIFO_DEPTH[0]};
`endif

  // Reset sensitivity only blocks commits at edges taken while reset is low;
  // contents are never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && ram_we) begin
      ram[ram_idx] <= mem_dout_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din_o <= 8'h00;
    end else if (!mem_wr_i) begin
      mem_din_o <= rd_data;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-serial memory responder at the far end of the CPU's byte-wide memory port. It services the memory stage's one-byte-per-cycle reads and writes from an internal RAM. Reads return data with one cycle of latency. Writes to the memory-mapped I/O window are routed to a character transmit FIFO and a halt register. The block sits beside the core in the top level, on the `mem_a`/`mem_wr`/`mem_dout`/`mem_din` wires.

## Interface
- `ADDR_WIDTH`, 17: RAM is 2^ADDR_WIDTH bytes, indexed by `mem_a_i[ADDR_WIDTH-1:0]`.
- `IO_BASE`, 32'h0003_0000: first byte address of the I/O window; addresses >= IO_BASE are I/O.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, >= 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous assert, active-low (0 = reset).
- `mem_wr_i` in 1: 1 = write cycle, 0 = read cycle.
- `mem_a_i` in 32: byte address, driven by the memory stage.
- `mem_dout_i` in 8: write data from the CPU.
- `mem_din_o` out 8: registered read data to the CPU.
- `io_tx_valid_o` out 1: FIFO non-empty.
- `io_tx_data_o` out 8: FIFO head byte.
- `io_tx_ready_i` in 1: consumer accepts the head when high together with valid.
- `io_full_o` out 1: FIFO full, combinational from the count; the core's stall logic uses it.
- `io_ovf_o` out 1: sticky overflow flag.
- `halt_o` out 1: sticky program-end flag.

## Operation
- Reset values:
  - `mem_din_o` = 8'h00.
  - FIFO empty: pointers 0, count 0, so `io_tx_valid_o` = 0 and `io_full_o` = 0.
  - `io_tx_data_o` = 8'h00 while empty.
  - `io_ovf_o` = 0, `halt_o` = 0.
  - RAM contents are not reset.
- RAM write: `mem_wr_i`=1 and address < IO_BASE -> `ram[a] <= mem_dout_i` at the edge. `mem_din_o` holds its previous value.
- RAM read: `mem_wr_i`=0 and address < IO_BASE -> `mem_din_o <= ram[a]` at the edge.
- I/O writes (offset = `mem_a_i` - IO_BASE):
  - Offset 0: push `mem_dout_i` into the FIFO.
  - Offset 4: set `halt_o`.
  - Other offsets: ignored.
- I/O reads:
  - Offset 0: return 8'h00.
  - Offset 4: return {6'b0, full, empty}.
  - Other offsets: return 8'h00.
- FIFO storage:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits; the extra bit is the wrap bit.
  - Full when the indices are equal and the wrap bits differ.
  - Empty when the pointers are equal.
  - Indices wrap modulo FIFO_DEPTH.
- FIFO pop: `io_tx_valid_o && io_tx_ready_i` advances the read pointer.
- FIFO push rules:
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - Simultaneous push and pop on a full FIFO: both happen and the count is unchanged.
  - A push on a full FIFO with no pop: the byte is dropped and `io_ovf_o` is set.
  - A push and pop on an empty FIFO: only the push takes effect, since valid was 0.
- After `halt_o`=1:
  - All RAM and I/O writes are ignored.
  - Reads are still served.
  - The FIFO keeps draining.
- `halt_o` and `io_ovf_o` clear only on reset.
- Reset asserted mid-access: outputs go immediately to their reset values. A write in flight at the same edge is not committed.

## Timing
- Read latency is 1 cycle. Address presented in cycle N -> `mem_din_o` valid in cycle N+1 and held until the next read edge. This matches the initiator sampling `din` two cycles after registering its address.
- Write latency is 0: the write commits at the edge ending the cycle the write is presented. A read of that address in the next cycle returns the new data.
- Back-to-back accesses at one per cycle are supported, with no bubbles.
- FIFO: a push at edge E -> `io_tx_valid_o`=1 and `io_tx_data_o` = the byte after E. A pop at edge E -> the next entry is presented after E.
- `io_full_o` updates in the cycle after the edge that fills the FIFO.
- No internal state machine beyond the FIFO pointers and sticky flags. The block is a pure responder with no request/ack.

## Configuration
- `MEM_RESP_IO_EN` defined:
  - The I/O window, TX FIFO, overflow flag and halt register are present, as above.
- `MEM_RESP_IO_EN` undefined:
  - No address decode; every address maps to RAM via `mem_a_i[ADDR_WIDTH-1:0]` (aliasing).
  - `io_tx_valid_o`, `io_tx_data_o`, `io_full_o`, `io_ovf_o` and `halt_o` are tied to 0.
  - `io_tx_ready_i` is ignored.

## Test plan
- Byte round-trip: write 8'hA5 at 0x0100 (cycle 0), read 0x0100 (cycle 1) -> `mem_din_o`=8'hA5 in cycle 2.
- Word sequence: write 0x12,0x34,0x56,0x78 to 0x0200..0x0203 on consecutive cycles, then read them on consecutive cycles -> 0x12,0x34,0x56,0x78 each one cycle after its address.
- Character output: with `io_tx_ready_i`=0, write 0x48 then 0x69 to 0x30000 -> valid=1, data=0x48. Raise ready for 2 cycles -> 0x48 then 0x69 pop, then valid=0.
- Overflow and boundary: with ready=0, push 9 bytes (DEPTH 8) -> `io_full_o`=1 after the 8th, 9th byte dropped, `io_ovf_o`=1. Then push with ready=1 while full -> accepted, count stays 8.
- Halt: write any byte to 0x30004 -> `halt_o`=1 next cycle. A later write of 0xFF to 0x0100 is ignored, and a read still returns the old value.
- Reset mid-stream: assert `rst`=0 with 3 bytes queued -> valid=0, `halt_o`=0, `mem_din_o`=0 immediately. RAM data written earlier is still readable after release.
